// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit: captures one op from execute, runs a req/gnt + rvalid bus
// transaction, and holds a write-back bundle. Optional LSU_MISALIGN_CHECK_EN traps misaligned half/word accesses.
module ysyx_24110006_lsu (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_mem_ren,
   input  logic        i_mem_wen,
   input  logic [3:0]  i_mem_wmask,
   input  logic [2:0]  i_mem_read_t,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   input  logic [31:0] i_result,
   input  logic        i_result_t,
   input  logic        i_reg_wen,
   input  logic [4:0]  i_reg_rd,
   input  logic [31:0] i_pc,
   input  logic        i_exception,
   input  logic [3:0]  i_mcause,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_result,
   output logic        o_reg_wen,
   output logic [4:0]  o_reg_rd,
   output logic [31:0] o_pc,
   output logic        o_exception,
   output logic [3:0]  o_mcause,
   output logic        o_bus_req,
   input  logic        i_bus_gnt,
   output logic        o_bus_wen,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_wstrb,
   input  logic        i_bus_rvalid,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, wdata_reg, result_reg, pc_reg, rdata_reg;
   logic [3:0]  wmask_reg, mcause_reg;
   logic [2:0]  read_t_reg;
   logic [4:0]  rd_reg;
   logic        store_reg, result_t_reg, reg_wen_reg, exc_reg;

   logic        accept, mem_op, misalign;
   logic [31:0] lane, load_data;

   assign accept = i_valid && (state_reg == IDLE);
   assign mem_op = i_mem_ren | i_mem_wen;

`ifdef LSU_MISALIGN_CHECK_EN
   // Stores are classified by strobe width, loads by the funct3 size bits.
   always_comb begin
      misalign = 1'b0;
      if (i_mem_wen) begin
         if (i_mem_wmask == 4'b0011)      misalign = i_mem_addr[0];
         else if (i_mem_wmask == 4'b1111) misalign = |i_mem_addr[1:0];
      end else begin
         if (i_mem_read_t[1:0] == 2'b01)      misalign = i_mem_addr[0];
         else if (i_mem_read_t[1:0] == 2'b10) misalign = |i_mem_addr[1:0];
      end
   end
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) state_reg <= IDLE;
      else            state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = (mem_op && !i_exception && !misalign) ? REQ : OUT;
         REQ:  if (i_bus_gnt) state_next = WAIT;
         WAIT: if (i_bus_rvalid) state_next = OUT;
         OUT:  if (i_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         addr_reg     <= '0;
         wdata_reg    <= '0;
         result_reg   <= '0;
         pc_reg       <= '0;
         rdata_reg    <= '0;
         wmask_reg    <= '0;
         mcause_reg   <= '0;
         read_t_reg   <= '0;
         rd_reg       <= '0;
         store_reg    <= 1'b0;
         result_t_reg <= 1'b0;
         reg_wen_reg  <= 1'b0;
         exc_reg      <= 1'b0;
      end else begin
         if (accept) begin
            addr_reg     <= i_mem_addr;
            wdata_reg    <= i_mem_wdata;
            result_reg   <= i_result;
            pc_reg       <= i_pc;
            rdata_reg    <= '0;
            wmask_reg    <= i_mem_wmask;
            read_t_reg   <= i_mem_read_t;
            rd_reg       <= i_reg_rd;
            store_reg    <= i_mem_wen;
            result_t_reg <= i_result_t;
            reg_wen_reg  <= i_reg_wen;
            exc_reg      <= i_exception | (mem_op & misalign);
            if (i_exception)           mcause_reg <= i_mcause;
            else if (mem_op & misalign) mcause_reg <= i_mem_wen ? 4'd6 : 4'd4;
            else                       mcause_reg <= 4'd0;
         end
         // Response is only honoured once the grant has moved us to WAIT.
         if ((state_reg == WAIT) && i_bus_rvalid) begin
            rdata_reg <= i_bus_rdata;
            if (i_bus_err) begin
               exc_reg    <= 1'b1;
               mcause_reg <= store_reg ? 4'd7 : 4'd5;
            end
         end
      end
   end

   assign lane = rdata_reg >> {addr_reg[1:0], 3'b000};

   always_comb begin
      load_data = '0;
      case (read_t_reg)
         3'b000: load_data = {{24{lane[7]}}, lane[7:0]};
         3'b001: load_data = {{16{lane[15]}}, lane[15:0]};
         3'b010: load_data = lane;
         3'b100: load_data = {24'd0, lane[7:0]};
         3'b101: load_data = {16'd0, lane[15:0]};
         default: load_data = '0;
      endcase
   end

   assign o_ready     = (state_reg == IDLE);
   assign o_valid     = (state_reg == OUT);
   assign o_result    = result_t_reg ? load_data : result_reg;
   assign o_reg_wen   = reg_wen_reg & ~exc_reg;
   assign o_reg_rd    = rd_reg;
   assign o_pc        = pc_reg;
   assign o_exception = exc_reg;
   assign o_mcause    = mcause_reg;

   // Lanes shifted past bit 31 fall off the top when misalignment is not trapped.
   assign o_bus_req   = (state_reg == REQ);
   assign o_bus_wen   = store_reg;
   assign o_bus_addr  = {addr_reg[31:2], 2'b00};
   assign o_bus_wstrb = wmask_reg << addr_reg[1:0];
   assign o_bus_wdata = wdata_reg << {addr_reg[1:0], 3'b000};

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Scoreboard bench for ysyx_24110006_lsu: expected write-back bundles are queued at issue
// and compared on each o_valid/i_ready handshake; bus payload is checked inline.
module tb_ysyx_24110006_lsu;

   logic        i_clock = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_valid = 1'b0, o_ready;
   logic        i_mem_ren = 1'b0, i_mem_wen = 1'b0;
   logic [3:0]  i_mem_wmask = '0;
   logic [2:0]  i_mem_read_t = '0;
   logic [31:0] i_mem_addr = '0, i_mem_wdata = '0, i_result = '0, i_pc = '0;
   logic        i_result_t = 1'b0, i_reg_wen = 1'b0;
   logic [4:0]  i_reg_rd = '0;
   logic        i_exception = 1'b0;
   logic [3:0]  i_mcause = '0;
   logic        o_valid, i_ready = 1'b1;
   logic [31:0] o_result, o_pc;
   logic        o_reg_wen, o_exception;
   logic [4:0]  o_reg_rd;
   logic [3:0]  o_mcause;
   logic        o_bus_req, i_bus_gnt = 1'b0, o_bus_wen;
   logic [31:0] o_bus_addr, o_bus_wdata;
   logic [3:0]  o_bus_wstrb;
   logic        i_bus_rvalid = 1'b0, i_bus_err = 1'b0;
   logic [31:0] i_bus_rdata = '0;

   typedef struct packed {
      logic [31:0] result;
      logic        reg_wen;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        exc;
      logic [3:0]  mcause;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   passes = 0;

   ysyx_24110006_lsu dut (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_wmask(i_mem_wmask),
      .i_mem_read_t(i_mem_read_t), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
      .i_result(i_result), .i_result_t(i_result_t), .i_reg_wen(i_reg_wen),
      .i_reg_rd(i_reg_rd), .i_pc(i_pc), .i_exception(i_exception), .i_mcause(i_mcause),
      .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_reg_wen(o_reg_wen),
      .o_reg_rd(o_reg_rd), .o_pc(o_pc), .o_exception(o_exception), .o_mcause(o_mcause),
      .o_bus_req(o_bus_req), .i_bus_gnt(i_bus_gnt), .o_bus_wen(o_bus_wen),
      .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb),
      .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
   );

   always #5 i_clock = ~i_clock;

   // Write-back scoreboard: every handshake must match the oldest queued expectation.
   always @(negedge i_clock) begin
      if (i_reset_n && o_valid && i_ready) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL wb_unexpected got res=%h pc=%h want no output", o_result, o_pc);
         end else begin
            e = sb.pop_front();
            if ({o_result, o_reg_wen, o_reg_rd, o_pc, o_exception, o_mcause} !== e) begin
               $display("FAIL wb_bundle got res=%h wen=%b rd=%0d pc=%h exc=%b mc=%0d want res=%h wen=%b rd=%0d pc=%h exc=%b mc=%0d",
                        o_result, o_reg_wen, o_reg_rd, o_pc, o_exception, o_mcause,
                        e.result, e.reg_wen, e.rd, e.pc, e.exc, e.mcause);
            end else begin
               passes++;
               $display("wb pc=%h res=%h wen=%b rd=%0d exc=%b mc=%0d ok",
                        o_pc, o_result, o_reg_wen, o_reg_rd, o_exception, o_mcause);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic ren, input logic wen, input logic [3:0] wmask,
                        input logic [2:0] rt, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] result, input logic res_t, input logic reg_wen,
                        input logic [4:0] rd, input logic [31:0] pc, input logic exc,
                        input logic [3:0] mc);
      int n = 0;
      while (!o_ready && n < 50) begin
         @(posedge i_clock); #1;
         n++;
      end
      if (!o_ready) begin
         checks++;
         $display("FAIL issue_ready got o_ready=%b want 1", o_ready);
      end
      i_mem_ren = ren; i_mem_wen = wen; i_mem_wmask = wmask; i_mem_read_t = rt;
      i_mem_addr = addr; i_mem_wdata = wdata; i_result = result; i_result_t = res_t;
      i_reg_wen = reg_wen; i_reg_rd = rd; i_pc = pc; i_exception = exc; i_mcause = mc;
      i_valid = 1'b1;
      @(posedge i_clock); #1;
      i_valid = 1'b0;
   endtask

   // Bus responder; noise drives junk rvalid before and with the grant.
   task automatic serve(input int gnt_delay, input int rv_delay, input logic [31:0] rdata,
                        input logic err, input logic noise);
      i_bus_rvalid = noise;
      i_bus_rdata  = 32'hDEADBEEF;
      repeat (gnt_delay) begin @(posedge i_clock); #1; end
      i_bus_gnt = 1'b1;
      @(posedge i_clock); #1;
      i_bus_gnt = 1'b0;
      i_bus_rvalid = 1'b0;
      repeat (rv_delay - 1) begin @(posedge i_clock); #1; end
      i_bus_rvalid = 1'b1; i_bus_rdata = rdata; i_bus_err = err;
      @(posedge i_clock); #1;
      i_bus_rvalid = 1'b0; i_bus_rdata = '0; i_bus_err = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge i_clock);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain got %0d pending want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      #3;
      checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_ready); else passes++;
      checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid); else passes++;
      checks++; if (o_bus_req !== 1'b0) $display("FAIL reset_bus_req got %b want 0", o_bus_req); else passes++;
      checks++; if (o_exception !== 1'b0) $display("FAIL reset_exc got %b want 0", o_exception); else passes++;
      checks++; if (o_reg_wen !== 1'b0) $display("FAIL reset_reg_wen got %b want 0", o_reg_wen); else passes++;
      checks++;
      if ({o_result, o_pc, o_reg_rd, o_mcause, o_bus_addr, o_bus_wdata, o_bus_wstrb, o_bus_wen} !== '0)
         $display("FAIL reset_data got res=%h pc=%h addr=%h wdata=%h want 0", o_result, o_pc, o_bus_addr, o_bus_wdata);
      else passes++;
      $display("reset state checked");
      @(negedge i_clock);
      i_reset_n = 1'b1;
   endtask

   task automatic test_lb();
      sb.push_back(exp_t'{32'hFFFFFF80, 1'b1, 5'd5, 32'h80000100, 1'b0, 4'd0});
      issue(1, 0, 4'b0000, 3'b000, 32'h80000003, 32'h0, 32'h0, 1, 1, 5'd5, 32'h80000100, 0, 4'd0);
      @(negedge i_clock);
      checks++; if (o_bus_req !== 1'b1) $display("FAIL lb_req got %b want 1", o_bus_req); else passes++;
      checks++; if (o_bus_addr !== 32'h80000000) $display("FAIL lb_addr got %h want 80000000", o_bus_addr); else passes++;
      checks++; if (o_bus_wen !== 1'b0) $display("FAIL lb_wen got %b want 0", o_bus_wen); else passes++;
      checks++; if (o_ready !== 1'b0) $display("FAIL lb_ready got %b want 0", o_ready); else passes++;
      serve(2, 3, 32'h80FF1234, 1'b0, 1'b1);
      drain();
   endtask

   task automatic test_sh();
      sb.push_back(exp_t'{32'h00000777, 1'b0, 5'd0, 32'h80000104, 1'b0, 4'd0});
      issue(0, 1, 4'b0011, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h777, 0, 0, 5'd0, 32'h80000104, 0, 4'd0);
      @(negedge i_clock);
      checks++; if (o_bus_wstrb !== 4'b1100) $display("FAIL sh_wstrb got %b want 1100", o_bus_wstrb); else passes++;
      checks++; if (o_bus_wdata !== 32'hABCD0000) $display("FAIL sh_wdata got %h want abcd0000", o_bus_wdata); else passes++;
      checks++; if (o_bus_addr !== 32'h80000000) $display("FAIL sh_addr got %h want 80000000", o_bus_addr); else passes++;
      checks++; if (o_bus_wen !== 1'b1) $display("FAIL sh_wen got %b want 1", o_bus_wen); else passes++;
      serve(1, 1, 32'h0, 1'b0, 1'b0);
      drain();
   endtask

   task automatic test_alu_stall();
      i_ready = 1'b0;
      sb.push_back(exp_t'{32'h12345678, 1'b1, 5'd7, 32'h80000200, 1'b0, 4'd0});
      issue(0, 0, 4'b0000, 3'b000, 32'h0, 32'h0, 32'h12345678, 0, 1, 5'd7, 32'h80000200, 0, 4'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clock);
         checks++; if (o_valid !== 1'b1) $display("FAIL alu_valid c%0d got %b want 1", c, o_valid); else passes++;
         checks++; if (o_result !== 32'h12345678) $display("FAIL alu_hold c%0d got %h want 12345678", c, o_result); else passes++;
         checks++; if (o_ready !== 1'b0) $display("FAIL alu_ready c%0d got %b want 0", c, o_ready); else passes++;
         checks++; if (o_bus_req !== 1'b0) $display("FAIL alu_bus_req c%0d got %b want 0", c, o_bus_req); else passes++;
      end
      @(posedge i_clock); #1;
      i_ready = 1'b1;
      drain();
   endtask

   task automatic test_bus_err();
      sb.push_back(exp_t'{32'h0, 1'b0, 5'd9, 32'h80000300, 1'b1, 4'd5});
      issue(1, 0, 4'b0000, 3'b010, 32'h80000010, 32'h0, 32'h0, 1, 1, 5'd9, 32'h80000300, 0, 4'd0);
      serve(1, 2, 32'h0, 1'b1, 1'b0);
      drain();
      sb.push_back(exp_t'{32'h00001234, 1'b0, 5'd2, 32'h80000304, 1'b1, 4'd7});
      issue(0, 1, 4'b0001, 3'b000, 32'h80000021, 32'h00000055, 32'h1234, 0, 0, 5'd2, 32'h80000304, 0, 4'd0);
      @(negedge i_clock);
      checks++; if (o_bus_wstrb !== 4'b0010) $display("FAIL sb_wstrb got %b want 0010", o_bus_wstrb); else passes++;
      checks++; if (o_bus_wdata !== 32'h00005500) $display("FAIL sb_wdata got %h want 00005500", o_bus_wdata); else passes++;
      serve(1, 1, 32'h0, 1'b1, 1'b0);
      drain();
      sb.push_back(exp_t'{32'hCAFEF00D, 1'b1, 5'd3, 32'h80000308, 1'b0, 4'd0});
      issue(0, 0, 4'b0000, 3'b000, 32'h0, 32'h0, 32'hCAFEF00D, 0, 1, 5'd3, 32'h80000308, 0, 4'd0);
      drain();
   endtask

   task automatic test_exception();
      sb.push_back(exp_t'{32'h0000BEEF, 1'b0, 5'd4, 32'h80000400, 1'b1, 4'd2});
      issue(1, 0, 4'b0000, 3'b010, 32'h80000008, 32'h0, 32'hBEEF, 0, 1, 5'd4, 32'h80000400, 1, 4'd2);
      @(negedge i_clock);
      checks++; if (o_bus_req !== 1'b0) $display("FAIL exc_bus_req got %b want 0", o_bus_req); else passes++;
      checks++; if (o_valid !== 1'b1) $display("FAIL exc_valid got %b want 1", o_valid); else passes++;
      drain();
   endtask

   task automatic test_loads();
      logic [31:0] addr_t[6] = '{32'h80000002, 32'h80000000, 32'h80000001, 32'h80000000, 32'h80000004, 32'h80000002};
      logic [2:0]  rt_t[6]   = '{3'b101, 3'b001, 3'b100, 3'b011, 3'b010, 3'b000};
      logic [31:0] rd_t[6]   = '{32'h80FF1234, 32'h0000F00F, 32'h80FF1234, 32'h12345678, 32'h89ABCDEF, 32'h807F0000};
      logic [31:0] exp_v[6]  = '{32'h000080FF, 32'hFFFFF00F, 32'h00000012, 32'h00000000, 32'h89ABCDEF, 32'h0000007F};
      for (int k = 0; k < 6; k++) begin
         sb.push_back(exp_t'{exp_v[k], 1'b1, 5'(k + 10), 32'h80000500 + 32'(4 * k), 1'b0, 4'd0});
         issue(1, 0, 4'b0000, rt_t[k], addr_t[k], 32'h0, 32'h0, 1, 1, 5'(k + 10),
               32'h80000500 + 32'(4 * k), 0, 4'd0);
         @(negedge i_clock);
         checks++;
         if (o_bus_addr !== (addr_t[k] & 32'hFFFFFFFC))
            $display("FAIL load%0d_addr got %h want %h", k, o_bus_addr, addr_t[k] & 32'hFFFFFFFC);
         else passes++;
         serve(1, 1, rd_t[k], 1'b0, 1'b0);
         drain();
      end
   endtask

   task automatic test_both();
      sb.push_back(exp_t'{32'h0, 1'b0, 5'd1, 32'h80000600, 1'b0, 4'd0});
      issue(1, 1, 4'b1111, 3'b010, 32'h80000004, 32'h01020304, 32'h0, 0, 0, 5'd1, 32'h80000600, 0, 4'd0);
      @(negedge i_clock);
      checks++; if (o_bus_wen !== 1'b1) $display("FAIL both_wen got %b want 1", o_bus_wen); else passes++;
      checks++; if (o_bus_wstrb !== 4'b1111) $display("FAIL both_wstrb got %b want 1111", o_bus_wstrb); else passes++;
      checks++; if (o_bus_wdata !== 32'h01020304) $display("FAIL both_wdata got %h want 01020304", o_bus_wdata); else passes++;
      serve(1, 1, 32'h0, 1'b0, 1'b0);
      drain();
   endtask

   task automatic test_misalign();
`ifdef LSU_MISALIGN_CHECK_EN
      sb.push_back(exp_t'{32'h0, 1'b0, 5'd6, 32'h80000700, 1'b1, 4'd4});
      issue(1, 0, 4'b0000, 3'b010, 32'h80000001, 32'h0, 32'h0, 1, 1, 5'd6, 32'h80000700, 0, 4'd0);
      @(negedge i_clock);
      checks++; if (o_bus_req !== 1'b0) $display("FAIL mis_lw_req got %b want 0", o_bus_req); else passes++;
      checks++; if (o_valid !== 1'b1) $display("FAIL mis_lw_valid got %b want 1", o_valid); else passes++;
      drain();
      sb.push_back(exp_t'{32'h00000042, 1'b0, 5'd0, 32'h80000704, 1'b1, 4'd6});
      issue(0, 1, 4'b0011, 3'b001, 32'h80000003, 32'h0000ABCD, 32'h42, 0, 0, 5'd0, 32'h80000704, 0, 4'd0);
      @(negedge i_clock);
      checks++; if (o_bus_req !== 1'b0) $display("FAIL mis_sh_req got %b want 0", o_bus_req); else passes++;
      drain();
`else
      sb.push_back(exp_t'{32'h00AABBCC, 1'b1, 5'd6, 32'h80000700, 1'b0, 4'd0});
      issue(1, 0, 4'b0000, 3'b010, 32'h80000001, 32'h0, 32'h0, 1, 1, 5'd6, 32'h80000700, 0, 4'd0);
      @(negedge i_clock);
      checks++; if (o_bus_req !== 1'b1) $display("FAIL mis_lw_req got %b want 1", o_bus_req); else passes++;
      checks++; if (o_bus_addr !== 32'h80000000) $display("FAIL mis_lw_addr got %h want 80000000", o_bus_addr); else passes++;
      serve(1, 1, 32'hAABBCCDD, 1'b0, 1'b0);
      drain();
      sb.push_back(exp_t'{32'h00000042, 1'b0, 5'd0, 32'h80000704, 1'b0, 4'd0});
      issue(0, 1, 4'b0011, 3'b001, 32'h80000003, 32'h0000ABCD, 32'h42, 0, 0, 5'd0, 32'h80000704, 0, 4'd0);
      @(negedge i_clock);
      checks++; if (o_bus_wstrb !== 4'b1000) $display("FAIL mis_sh_wstrb got %b want 1000", o_bus_wstrb); else passes++;
      checks++; if (o_bus_wdata !== 32'hCD000000) $display("FAIL mis_sh_wdata got %h want cd000000", o_bus_wdata); else passes++;
      serve(1, 1, 32'h0, 1'b0, 1'b0);
      drain();
`endif
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      for (int k = 0; k < 4; k++) begin
         r = $urandom;
         sb.push_back(exp_t'{r, 1'b1, 5'(k + 20), 32'h80000800 + 32'(4 * k), 1'b0, 4'd0});
         issue(0, 0, 4'b0000, 3'b000, 32'h0, 32'h0, r, 0, 1, 5'(k + 20), 32'h80000800 + 32'(4 * k), 0, 4'd0);
      end
      drain();
   endtask

   task automatic test_async_reset();
      issue(1, 0, 4'b0000, 3'b010, 32'h80000040, 32'h0, 32'h0, 1, 1, 5'd8, 32'h80000900, 0, 4'd0);
      i_bus_gnt = 1'b1;
      @(posedge i_clock); #1;
      i_bus_gnt = 1'b0;
      checks++;
      if (o_bus_req !== 1'b0 || o_ready !== 1'b0 || o_valid !== 1'b0)
         $display("FAIL wait_state got req=%b rdy=%b vld=%b want 0 0 0", o_bus_req, o_ready, o_valid);
      else passes++;
      #2 i_reset_n = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) $display("FAIL arst_ready got %b want 1", o_ready); else passes++;
      checks++; if (o_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", o_valid); else passes++;
      checks++; if (o_bus_req !== 1'b0) $display("FAIL arst_bus_req got %b want 0", o_bus_req); else passes++;
      checks++; if (o_pc !== 32'h0) $display("FAIL arst_pc got %h want 0", o_pc); else passes++;
      $display("async reset in WAIT checked");
      @(negedge i_clock);
      i_reset_n = 1'b1;
      sb.push_back(exp_t'{32'h0BADF00D, 1'b1, 5'd11, 32'h80000904, 1'b0, 4'd0});
      issue(0, 0, 4'b0000, 3'b000, 32'h0, 32'h0, 32'h0BADF00D, 0, 1, 5'd11, 32'h80000904, 0, 4'd0);
      drain();
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_alu_stall();
      test_bus_err();
      test_exception();
      test_loads();
      test_both();
      test_misalign();
      test_back_to_back();
      test_async_reset();
      repeat (3) @(negedge i_clock);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
